// File: rtl/spi_adc_reader_pkg.sv
// Shared state type, frame geometry and command bits for the MCP3002 reader.
package adc_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

    localparam int          SAMPLE_W       = 10;
    localparam logic [4:0]  FRAME_BITS     = 5'd16;
    localparam logic [4:0]  FIRST_DATA_BIT = 5'd6;
    localparam logic [4:0]  LAST_DATA_BIT  = 5'd15;

    localparam logic CMD_START = 1'b1;
    localparam logic CMD_SGL   = 1'b1;
    localparam logic CMD_MSBF  = 1'b1;

    // MOSI level for frame bit pos (1-based); everything past MSBF is zero.
    function automatic logic cmd_bit(input logic [4:0] pos, input logic channel);
        case (pos)
            5'd1:    cmd_bit = CMD_START;
            5'd2:    cmd_bit = CMD_SGL;
            5'd3:    cmd_bit = channel;
            5'd4:    cmd_bit = CMD_MSBF;
            default: cmd_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_adc_reader_if.sv
// SPI pins plus the sample output toward the audio processor.
interface spi_adc_reader_if;
    import adc_pkg::*;

    logic                adc_cs_n;
    logic                adc_sck;
    logic                adc_mosi;
    logic                adc_miso;
    logic                data_valid;
    logic [SAMPLE_W-1:0] data_out;

    modport master (
        output adc_cs_n, adc_sck, adc_mosi, data_valid, data_out,
        input  adc_miso
    );

    modport slave (
        input  adc_cs_n, adc_sck, adc_mosi, data_valid, data_out,
        output adc_miso
    );
endinterface

// File: rtl/spi_adc_reader_tick_gen.sv
// Modulo-PERIOD counter with a registered one-cycle pulse at wrap; clr holds it at zero.
module tick_gen #(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int          W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (!clr) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/spi_adc_reader.sv
// Periodic MCP3002 reader: sample-rate tick, mode-0 SPI master, 10-bit result latch.
module spi_adc_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_DIV = 5000,
    parameter bit CHANNEL    = 1'b0
) (
    input  logic             sysclk,
    input  logic             rst_n,
    spi_adc_reader_if.master bus
);
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 1");
    end
    if (SAMPLE_DIV <= 34 * CLK_DIV) begin : g_bad_sample_div
        $error("SAMPLE_DIV must exceed 34*CLK_DIV");
    end

    state_e              state_q, state_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [SAMPLE_W-1:0] dout_q, dout_d;
    logic                dv_q, dv_d;

    logic       smp_tick, half_tick, half_clr;
    logic [4:0] nxt_bit;

    assign nxt_bit  = bit_cnt_q + 5'd1;
    // Half-period counter starts on the tick cycle itself so rising edge 1 lands CLK_DIV after CS falls.
    assign half_clr = !(state_d == SETUP || state_d == SHIFT);

    tick_gen #(.PERIOD(SAMPLE_DIV)) u_smp_tick (
        .clk(sysclk), .rst_n(rst_n), .clr(1'b0), .tick(smp_tick)
    );

    tick_gen #(.PERIOD(CLK_DIV)) u_half_tick (
        .clk(sysclk), .rst_n(rst_n), .clr(half_clr), .tick(half_tick)
    );

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        dv_d      = dv_q;
        case (state_q)
            IDLE: begin
                if (smp_tick) begin
                    state_d   = SETUP;
                    cs_n_d    = 1'b0;
                    dv_d      = 1'b0;
                    bit_cnt_d = '0;
                    mosi_d    = cmd_bit(5'd1, CHANNEL);
                end
            end
            SETUP, SHIFT: begin
                // Wait one cycle after falling edge 16 before releasing CS.
                if (state_q == SHIFT && bit_cnt_q == FRAME_BITS && !sck_q) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    dout_d  = shreg_q;
                    dv_d    = 1'b1;
                end else if (half_tick) begin
                    if (!sck_q) begin
                        state_d   = SHIFT;
                        sck_d     = 1'b1;
                        bit_cnt_d = nxt_bit;
                        if (nxt_bit >= FIRST_DATA_BIT && nxt_bit <= LAST_DATA_BIT)
                            shreg_d = {shreg_q[SAMPLE_W-2:0], bus.adc_miso};
                    end else begin
                        sck_d  = 1'b0;
                        mosi_d = cmd_bit(nxt_bit, CHANNEL);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
        end
    end

    assign bus.adc_cs_n   = cs_n_q;
    assign bus.adc_sck    = sck_q;
    assign bus.adc_mosi   = mosi_q;
    assign bus.data_valid = dv_q;
    assign bus.data_out   = dout_q;
endmodule
